// File: rtl/athos_pkg.sv
// Shared types and constants for the ATHOS issue front end: instruction encodings,
// functional-unit numbering (also used by the result multiplexer) and FSM states.
package athos_pkg;

    localparam int unsigned OUT_W     = 32;
    localparam int unsigned NUM_UNITS = 15;

    typedef logic [OUT_W-1:0] out_t;
    typedef logic [3:0]       unit_idx_t;
    typedef logic [3:0]       mode_t;
    typedef logic [6:0]       funct7_t;

    localparam logic [1:0] INSR_R = 2'b01;
    localparam logic [1:0] INSR_I = 2'b10;

    localparam mode_t MODE_LOAD64    = 4'd0;
    localparam mode_t MODE_MONTG     = 4'd1;
    localparam mode_t MODE_BARRETT   = 4'd2;
    localparam mode_t MODE_CBD       = 4'd3;
    localparam mode_t MODE_KEM       = 4'd4;
    localparam mode_t MODE_POLY      = 4'd5;
    localparam mode_t MODE_LOAD24_LE = 4'd6;
    localparam mode_t MODE_LOAD32_LE = 4'd7;

    localparam funct7_t MONTG_K_MODE = 7'h01;

    localparam funct7_t POLY_COMPRESS         = 7'h00;
    localparam funct7_t POLY_COMPRESS_2       = 7'h01;
    localparam funct7_t POLY_VEC_COMPRESS     = 7'h02;
    localparam funct7_t POLY_VEC_COMPRESS2    = 7'h03;
    localparam funct7_t POLY_DECOMPRESS_1     = 7'h04;
    localparam funct7_t POLY_DECOMPRESS_2     = 7'h05;
    localparam funct7_t POLY_DECOMPRESS_3     = 7'h06;
    localparam funct7_t POLY_VEC_DECOMPRESS   = 7'h07;
    localparam funct7_t POLY_VEC_DECOMPRESS2  = 7'h08;
    localparam funct7_t POLY_TOBYTES_1        = 7'h09;
    localparam funct7_t POLY_TOBYTES_2        = 7'h0A;
    localparam funct7_t POLY_TOBYTES_3        = 7'h0B;
    localparam funct7_t POLY_FROMBYTES_1      = 7'h0C;
    localparam funct7_t POLY_FROMBYTES_2      = 7'h0D;
    localparam funct7_t POLY_FROMMSG          = 7'h0E;
    localparam funct7_t POLY_TOMSG_1          = 7'h0F;
    localparam funct7_t POLY_TOMSG_2          = 7'h10;
    localparam funct7_t POLY_TOMSG_3          = 7'h11;
    localparam funct7_t POLY_TOMSG_4          = 7'h12;
    localparam funct7_t POLY_TOMSG_5          = 7'h13;
    localparam funct7_t POLY_TOMSG_6          = 7'h14;
    localparam funct7_t POLY_TOMSG_7          = 7'h15;
    localparam funct7_t POLY_TOMSG_8          = 7'h16;

    // Index 0 means "no unit"; indices 1 and 4 are not reachable from decode.
    localparam unit_idx_t U_NONE       = 4'd0;
    localparam unit_idx_t U_LOAD64     = 4'd2;
    localparam unit_idx_t U_MONTG      = 4'd3;
    localparam unit_idx_t U_BARRETT    = 4'd5;
    localparam unit_idx_t U_LOAD24     = 4'd6;
    localparam unit_idx_t U_LOAD32     = 4'd7;
    localparam unit_idx_t U_CBD        = 4'd8;
    localparam unit_idx_t U_COMPRESS   = 4'd9;
    localparam unit_idx_t U_DECOMPRESS = 4'd10;
    localparam unit_idx_t U_TOBYTES    = 4'd11;
    localparam unit_idx_t U_FROMBYTES  = 4'd12;
    localparam unit_idx_t U_FROMMSG    = 4'd13;
    localparam unit_idx_t U_TOMSG      = 4'd14;
    localparam unit_idx_t U_KEM        = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RESULT
    } dispatch_state_t;

    // Unit k maps to bit k-1; index 0 yields no bit.
    function automatic logic [NUM_UNITS-1:0] unit_onehot(unit_idx_t idx);
        return (idx == U_NONE) ? '0 : (NUM_UNITS'(1) << (idx - 4'd1));
    endfunction

endpackage

// File: rtl/athos_issue_decode.sv
// Combinational decode of (insr, mode, funct7) to a functional-unit index;
// index 0 marks an unsupported instruction.
module athos_issue_decode
    import athos_pkg::*;
(
    input  logic [1:0] insr,
    input  mode_t      mode,
    input  funct7_t    funct7,
    output unit_idx_t  idx
);

    always_comb begin
        idx = U_NONE;
        if (insr == INSR_R) begin
            case (mode)
                MODE_LOAD64:  idx = U_LOAD64;
                MODE_MONTG:   if (funct7 == MONTG_K_MODE) idx = U_MONTG;
                MODE_BARRETT: idx = U_BARRETT;
                MODE_CBD:     idx = U_CBD;
                MODE_KEM:     idx = U_KEM;
                MODE_POLY: begin
                    case (funct7)
                        POLY_COMPRESS, POLY_COMPRESS_2,
                        POLY_VEC_COMPRESS, POLY_VEC_COMPRESS2:       idx = U_COMPRESS;
                        POLY_DECOMPRESS_1, POLY_DECOMPRESS_2, POLY_DECOMPRESS_3,
                        POLY_VEC_DECOMPRESS, POLY_VEC_DECOMPRESS2:   idx = U_DECOMPRESS;
                        POLY_TOBYTES_1, POLY_TOBYTES_2, POLY_TOBYTES_3: idx = U_TOBYTES;
                        POLY_FROMBYTES_1, POLY_FROMBYTES_2:          idx = U_FROMBYTES;
                        POLY_FROMMSG:                                idx = U_FROMMSG;
                        POLY_TOMSG_1, POLY_TOMSG_2, POLY_TOMSG_3, POLY_TOMSG_4,
                        POLY_TOMSG_5, POLY_TOMSG_6, POLY_TOMSG_7, POLY_TOMSG_8:
                                                                     idx = U_TOMSG;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end else if (insr == INSR_I) begin
            if (mode == MODE_LOAD24_LE)      idx = U_LOAD24;
            else if (mode == MODE_LOAD32_LE) idx = U_LOAD32;
        end
    end

endmodule

// File: rtl/athos_dispatch.sv
// ATHOS issue front end: decodes one instruction, launches its unit, waits for done
// (or times out) and returns the captured result over a valid/ready handshake.
module athos_dispatch
    import athos_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ID_W           = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [1:0]           issue_insr_i,
    input  mode_t                issue_mode_i,
    input  funct7_t              issue_funct7_i,
    input  logic [XLEN-1:0]      issue_rs1_i,
    input  logic [XLEN-1:0]      issue_rs2_i,
    input  logic [ID_W-1:0]      issue_id_i,
    output logic                 issue_accept_o,
    output logic [NUM_UNITS-1:0] unit_start_o,
    output unit_idx_t            unit_sel_o,
    output logic [XLEN-1:0]      unit_rs1_o,
    output logic [XLEN-1:0]      unit_rs2_o,
    output funct7_t              unit_funct7_o,
    input  logic [NUM_UNITS-1:0] unit_done_i,
    input  out_t                 result_data_i,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output out_t                 result_data_o,
    output logic [ID_W-1:0]      result_id_o,
    output logic                 result_err_o,
    output logic                 busy_o
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dispatch_state_t  state_q, state_d;
    unit_idx_t        dec_idx, idx_q;
    logic [XLEN-1:0]  rs1_q, rs2_q;
    funct7_t          f7_q;
    logic [ID_W-1:0]  id_q;
    out_t             data_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             take, done_hit, tmo_hit, sel_done;

    athos_issue_decode u_decode (
        .insr   (issue_insr_i),
        .mode   (issue_mode_i),
        .funct7 (issue_funct7_i),
        .idx    (dec_idx)
    );

    // Only the active unit's done bit counts; everything else on the bus is noise.
    assign sel_done = |(unit_done_i & unit_onehot(idx_q));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        done_hit = 1'b0;
        tmo_hit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue_valid_i && dec_idx != U_NONE) begin
                    take    = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                // Done takes priority over a timeout landing in the same cycle.
                if (sel_done) begin
                    done_hit = 1'b1;
                    state_d  = ST_RESULT;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: if (result_ready_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= U_NONE;
            rs1_q  <= '0;
            rs2_q  <= '0;
            f7_q   <= '0;
            id_q   <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (take) begin
                idx_q <= dec_idx;
                rs1_q <= issue_rs1_i;
                rs2_q <= issue_rs2_i;
                f7_q  <= issue_funct7_i;
                id_q  <= issue_id_i;
            end
            if (state_q == ST_START)     cnt_q <= '0;
            else if (state_q == ST_WAIT) cnt_q <= cnt_q + 1'b1;
            if (done_hit) begin
                data_q <= result_data_i;
                err_q  <= 1'b0;
            end else if (tmo_hit) begin
                data_q <= '0;
                err_q  <= 1'b1;
            end
        end
    end

    assign issue_ready_o  = (state_q == ST_IDLE);
    assign issue_accept_o = issue_valid_i && (state_q == ST_IDLE) && (dec_idx != U_NONE);
    assign unit_start_o   = (state_q == ST_START) ? unit_onehot(idx_q) : '0;
    assign unit_sel_o     = (state_q == ST_IDLE) ? U_NONE : idx_q;
    assign unit_rs1_o     = rs1_q;
    assign unit_rs2_o     = rs2_q;
    assign unit_funct7_o  = f7_q;
    assign result_valid_o = (state_q == ST_RESULT);
    assign result_data_o  = data_q;
    assign result_id_o    = id_q;
    assign result_err_o   = err_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_athos_dispatch.sv
// Randomized self-checking bench for athos_dispatch against a cycle-level
// transaction model (decode table + fixed handshake latencies + timeout rule).
module tb_athos_dispatch;
    import athos_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid, issue_ready, issue_accept;
    logic [1:0]  insr;
    logic [3:0]  mode;
    logic [6:0]  f7;
    logic [31:0] rs1, rs2;
    logic [3:0]  id;
    logic [14:0] start, done;
    logic [3:0]  sel;
    logic [31:0] u_rs1, u_rs2;
    logic [6:0]  u_f7;
    logic [31:0] rdata_i, rdata_o;
    logic        rvalid, rready, rerr, busy;
    logic [3:0]  rid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    athos_dispatch #(.XLEN(32), .ID_W(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .issue_insr_i(insr), .issue_mode_i(mode), .issue_funct7_i(f7),
        .issue_rs1_i(rs1), .issue_rs2_i(rs2), .issue_id_i(id),
        .issue_accept_o(issue_accept),
        .unit_start_o(start), .unit_sel_o(sel),
        .unit_rs1_o(u_rs1), .unit_rs2_o(u_rs2), .unit_funct7_o(u_f7),
        .unit_done_i(done), .result_data_i(rdata_i),
        .result_valid_o(rvalid), .result_ready_i(rready),
        .result_data_o(rdata_o), .result_id_o(rid), .result_err_o(rerr),
        .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode: POLY sub-ops form contiguous funct7 ranges.
    function automatic int ref_idx(input logic [1:0] i, input logic [3:0] m, input logic [6:0] f);
        if (i == 2'b10) begin
            if (m == MODE_LOAD24_LE) return 6;
            if (m == MODE_LOAD32_LE) return 7;
            return 0;
        end
        if (i != 2'b01) return 0;
        if (m == MODE_LOAD64)  return 2;
        if (m == MODE_MONTG)   return (f == MONTG_K_MODE) ? 3 : 0;
        if (m == MODE_BARRETT) return 5;
        if (m == MODE_CBD)     return 8;
        if (m == MODE_KEM)     return 15;
        if (m == MODE_POLY) begin
            if (f <= 7'd3)  return 9;
            if (f <= 7'd8)  return 10;
            if (f <= 7'd11) return 11;
            if (f <= 7'd13) return 12;
            if (f == 7'd14) return 13;
            if (f <= 7'd22) return 14;
        end
        return 0;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, issue_ready, 1);
        chk({tag, "_accept"}, issue_accept, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_urs"}, {u_rs1, u_rs2}, 0);
        chk({tag, "_uf7"}, u_f7, 0);
        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_rdata"}, rdata_o, 0);
        chk({tag, "_rid_err"}, {rid, rerr}, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // One issue-to-result transaction. done_dly = WAIT cycle index of the done
    // pulse; values >= TMO mean the unit never answers.
    task automatic run_txn(input logic [1:0] ti, input logic [3:0] tm, input logic [6:0] tf,
                           input logic [31:0] t1, input logic [31:0] t2, input logic [3:0] tid,
                           input int done_dly, input int bp, input bit early,
                           input bit fix_data, input logic [31:0] fixed);
        int          exp;
        int          last;
        bit          tmo;
        logic [14:0] mask;
        logic [31:0] exp_data;
        exp = ref_idx(ti, tm, tf);
        insr = ti; mode = tm; f7 = tf; rs1 = t1; rs2 = t2; id = tid;
        issue_valid = 1'b1;
        #2;
        chk("issue_ready", issue_ready, 1);
        chk("accept", issue_accept, (exp != 0));
        tick();
        issue_valid = 1'b0;
        if (exp == 0) begin
            #2;
            chk("rej_busy", busy, 0);
            chk("rej_ready", issue_ready, 1);
            chk("rej_start", start, 0);
            tick();
            return;
        end
        mask = 15'(1 << (exp - 1));
        done = 15'($urandom) & ~mask;
        if (early) done = done | mask;
        #2;
        chk("start", start, mask);
        chk("sel", sel, exp);
        chk("urs", {u_rs1, u_rs2}, {t1, t2});
        chk("uf7", u_f7, tf);
        chk("busy", busy, 1);
        tick();
        tmo = (done_dly >= TMO);
        last = tmo ? TMO - 1 : done_dly;
        exp_data = 32'h0;
        for (int w = 0; w <= last; w++) begin
            rdata_i = $urandom;
            done = 15'($urandom) & ~mask;
            if (!tmo && w == done_dly) begin
                if (fix_data) rdata_i = fixed;
                done = done | mask;
                exp_data = rdata_i;
            end
            #2;
            chk("wait_valid", rvalid, 0);
            chk("wait_start", start, 0);
            chk("wait_sel", sel, exp);
            tick();
        end
        done = '0;
        for (int b = 0; b <= bp; b++) begin
            rready = (b == bp);
            issue_valid = (b != bp);
            insr = 2'b01; mode = MODE_BARRETT;
            rdata_i = $urandom;
            done = 15'($urandom);
            #2;
            chk("res_valid", rvalid, 1);
            chk("res_data", rdata_o, exp_data);
            chk("res_id_err", {rid, rerr}, {tid, tmo});
            chk("res_ready", issue_ready, 0);
            chk("res_accept", issue_accept, 0);
            chk("res_sel", sel, exp);
            tick();
        end
        rready = 1'b0; issue_valid = 1'b0; done = '0;
        #2;
        chk("post_ready", issue_ready, 1);
        chk("post_valid", rvalid, 0);
        chk("post_sel", sel, 0);
        tick();
    endtask

    initial begin
        logic [1:0] ri;
        logic [3:0] rm;
        logic [6:0] rf;
        int         dd;
        issue_valid = 0; insr = 0; mode = 0; f7 = 0; rs1 = 0; rs2 = 0; id = 0;
        done = 0; rdata_i = 0; rready = 0;
        repeat (3) @(posedge clk);
        #3;
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Barrett: done at T+4 with 0x1234 -> result at T+5
        run_txn(2'b01, MODE_BARRETT, 7'h00, 32'h0000_0D01, 32'h5, 4'd3, 2, 0, 0, 1, 32'h1234);
        // Rejects and decode sweep
        run_txn(2'b11, MODE_BARRETT, 7'h00, 32'h1, 32'h2, 4'd1, 0, 0, 0, 0, 0);
        run_txn(2'b01, MODE_MONTG, 7'h02, 32'h1, 32'h2, 4'd1, 0, 0, 0, 0, 0);
        run_txn(2'b01, MODE_MONTG, MONTG_K_MODE, 32'h7, 32'h8, 4'd2, 0, 0, 0, 0, 0);
        run_txn(2'b01, MODE_POLY, POLY_TOMSG_5, 32'hA, 32'hB, 4'd4, 1, 0, 0, 0, 0);
        run_txn(2'b10, MODE_LOAD32_LE, 7'h00, 32'hC, 32'hD, 4'd5, 3, 0, 0, 0, 0);
        run_txn(2'b01, MODE_LOAD24_LE, 7'h00, 32'hC, 32'hD, 4'd5, 3, 0, 0, 0, 0);
        // Backpressure, timeout, done/timeout tie, done in START ignored
        run_txn(2'b01, MODE_KEM, 7'h00, 32'hE, 32'hF, 4'd6, 4, 5, 0, 0, 0);
        run_txn(2'b01, MODE_CBD, 7'h00, 32'h10, 32'h11, 4'd7, TMO + 5, 2, 0, 0, 0);
        run_txn(2'b01, MODE_LOAD64, 7'h00, 32'h12, 32'h13, 4'd8, TMO - 1, 0, 0, 0, 0);
        run_txn(2'b01, MODE_POLY, POLY_FROMMSG, 32'h14, 32'h15, 4'd9, 0, 1, 1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            ri = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3))
               : (($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01);
            rm = 4'($urandom_range(0, 9));
            rf = (rm == MODE_POLY) ? 7'($urandom_range(0, 25)) : 7'($urandom_range(0, 2));
            dd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TMO - 2, TMO + 4))
                                             : int'($urandom_range(0, 6));
            run_txn(ri, rm, rf, $urandom, $urandom, 4'($urandom), dd,
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, 0);
        end

        // Reset during WAIT, then a stale done must not produce a result
        insr = 2'b01; mode = MODE_KEM; f7 = 0; rs1 = 32'hDEAD; rs2 = 32'hBEEF; id = 4'd9;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        tick();
        tick();
        #2;
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_wait");
        tick();
        rst_n = 1'b1;
        tick();
        done = 15'h4000;
        #2;
        chk("stray_ready", issue_ready, 1);
        tick();
        done = '0;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("stray_valid", rvalid, 0);
            chk("stray_busy", busy, 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
